// File: rtl/acq_sequencer_if.sv
// Run-control bus between the acquisition host logic and acq_sequencer.
// master drives commands, config and datapath status; slave is the sequencer.
interface acq_sequencer_if #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned COUNT_W  = 32
);
    logic                cmd_start;
    logic                cmd_abort;
    logic [7:0]          cfg_clock_divisor;
    logic [CHANNELS-1:0] cfg_channel_enable;
    logic [CHANNELS-1:0] cfg_trig_mask;
    logic [CHANNELS-1:0] cfg_trig_value;
    logic [COUNT_W-1:0]  cfg_word_limit;
    logic [CHANNELS-1:0] probe;
    logic                sample_data_avail;
    logic                stalled;

    logic                fcd_rst;
    logic                acq_enable;
    logic [7:0]          clock_divisor;
    logic [CHANNELS-1:0] channel_enable;
    logic [2:0]          state;
    logic [COUNT_W-1:0]  word_count;
    logic                err_overflow;
    logic                err_config;

    modport master (
        output cmd_start, cmd_abort, cfg_clock_divisor, cfg_channel_enable, cfg_trig_mask,
               cfg_trig_value, cfg_word_limit, probe, sample_data_avail, stalled,
        input  fcd_rst, acq_enable, clock_divisor, channel_enable, state, word_count,
               err_overflow, err_config
    );

    modport slave (
        input  cmd_start, cmd_abort, cfg_clock_divisor, cfg_channel_enable, cfg_trig_mask,
               cfg_trig_value, cfg_word_limit, probe, sample_data_avail, stalled,
        output fcd_rst, acq_enable, clock_divisor, channel_enable, state, word_count,
               err_overflow, err_config
    );
endinterface

// File: rtl/acq_sequencer.sv
// Run-control FSM for the sampling datapath: config freeze, datapath reset pulse,
// masked probe trigger and word-limited / stall-terminated acquisition gating.
module acq_sequencer #(
    parameter int unsigned CHANNELS      = 16,
    parameter int unsigned COUNT_W       = 32,
    parameter int unsigned RST_PULSE_LEN = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    acq_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RSTP  = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam int unsigned PW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_LEN - 1);

    logic [2:0]          r_state;
    logic                r_fcd_rst;
    logic                r_acq_enable;
    logic [7:0]          r_clock_divisor;
    logic [CHANNELS-1:0] r_channel_enable;
    logic [CHANNELS-1:0] r_trig_mask;
    logic [CHANNELS-1:0] r_trig_value;
    logic [COUNT_W-1:0]  r_word_limit;
    logic [COUNT_W-1:0]  r_word_count;
    logic                r_err_overflow;
    logic                r_err_config;
    logic [PW-1:0]       r_pulse_cnt;
    logic                r_match;

    logic                w_start_ok;
    logic                w_start_bad;
    logic                w_probe_match;
    logic [COUNT_W-1:0]  w_count_nxt;
    logic                w_limit_hit;

    always_comb begin
        // Abort takes priority, so a start in the same cycle is never evaluated.
        w_start_ok    = bus.cmd_start && !bus.cmd_abort && (bus.cfg_channel_enable != '0);
        w_start_bad   = bus.cmd_start && !bus.cmd_abort && (bus.cfg_channel_enable == '0);
        w_probe_match = ((bus.probe ^ r_trig_value) & r_trig_mask) == '0;
        w_count_nxt   = r_word_count;
        if (bus.sample_data_avail && !(&r_word_count)) begin
            w_count_nxt = r_word_count + COUNT_W'(1);
        end
        w_limit_hit = (r_word_limit != '0) && bus.sample_data_avail
                      && (w_count_nxt == r_word_limit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_fcd_rst        <= 1'b0;
            r_acq_enable     <= 1'b0;
            r_clock_divisor  <= '0;
            r_channel_enable <= '0;
            r_trig_mask      <= '0;
            r_trig_value     <= '0;
            r_word_limit     <= '0;
            r_word_count     <= '0;
            r_err_overflow   <= 1'b0;
            r_err_config     <= 1'b0;
            r_pulse_cnt      <= '0;
            r_match          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_start_ok) begin
                        r_state          <= S_RSTP;
                        r_fcd_rst        <= 1'b1;
                        r_pulse_cnt      <= '0;
                        r_word_count     <= '0;
                        r_err_overflow   <= 1'b0;
                        r_err_config     <= 1'b0;
                        r_clock_divisor  <= bus.cfg_clock_divisor;
                        r_channel_enable <= bus.cfg_channel_enable;
                        r_trig_mask      <= bus.cfg_trig_mask;
                        r_trig_value     <= bus.cfg_trig_value;
                        r_word_limit     <= bus.cfg_word_limit;
                    end else if (w_start_bad) begin
                        r_state      <= S_ERROR;
                        r_err_config <= 1'b1;
                    end
                end
                S_RSTP: begin
                    if (r_pulse_cnt == PULSE_LAST) begin
                        r_fcd_rst <= 1'b0;
                        r_match   <= 1'b0;
                        // An empty trigger mask means trigger immediately.
                        if (r_trig_mask == '0) begin
                            r_state      <= S_RUN;
                            r_acq_enable <= 1'b1;
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + PW'(1);
                    end
                end
                S_ARMED: begin
                    r_match <= w_probe_match;
                    if (r_match) begin
                        r_state      <= S_RUN;
                        r_acq_enable <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_word_count <= w_count_nxt;
                    if (bus.stalled) begin
                        r_state        <= S_ERROR;
                        r_err_overflow <= 1'b1;
                        r_acq_enable   <= 1'b0;
                    end else if (w_limit_hit) begin
                        r_state      <= S_DONE;
                        r_acq_enable <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_acq_enable <= 1'b0;
                    r_fcd_rst    <= 1'b0;
                end
            endcase

            if (bus.cmd_abort && (r_state != S_IDLE)) begin
                r_state      <= S_IDLE;
                r_acq_enable <= 1'b0;
                r_fcd_rst    <= 1'b0;
                r_word_count <= r_word_count;
            end
        end
    end

    assign bus.fcd_rst        = r_fcd_rst;
    assign bus.acq_enable     = r_acq_enable;
    assign bus.clock_divisor  = r_clock_divisor;
    assign bus.channel_enable = r_channel_enable;
    assign bus.state          = r_state;
    assign bus.word_count     = r_word_count;
    assign bus.err_overflow   = r_err_overflow;
    assign bus.err_config     = r_err_config;
endmodule

// File: tb/tb_acq_sequencer.sv
// Scenario bench for acq_sequencer: directed run-control cases plus randomized
// strobe/stall/limit runs checked against a per-run outcome model.
module tb_acq_sequencer;
    localparam int unsigned CH = 16;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0]  exp_div  = '0;
    logic [15:0] exp_chan = '0;

    always #5 clk = ~clk;

    acq_sequencer_if #(.CHANNELS(CH), .COUNT_W(CW)) u_if ();

    acq_sequencer #(.CHANNELS(CH), .COUNT_W(CW), .RST_PULSE_LEN(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] chan, input logic [15:0] mask,
                            input logic [15:0] val, input logic [31:0] limit,
                            input logic [7:0] div);
        u_if.cfg_channel_enable = chan;
        u_if.cfg_trig_mask      = mask;
        u_if.cfg_trig_value     = val;
        u_if.cfg_word_limit     = limit;
        u_if.cfg_clock_divisor  = div;
        u_if.cmd_start          = 1'b1;
        tick();
        u_if.cmd_start = 1'b0;
        if (chan != '0) begin
            exp_chan = chan;
            exp_div  = div;
        end
    endtask

    task automatic wait_state(input logic [2:0] s, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (u_if.state == s) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (u_if.state !== 3'd0 || u_if.acq_enable !== 1'b0 || u_if.fcd_rst !== 1'b0 ||
            u_if.word_count !== '0 || u_if.err_overflow !== 1'b0 || u_if.err_config !== 1'b0 ||
            u_if.clock_divisor !== '0 || u_if.channel_enable !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got state=%0d acq=%b fcd=%b cnt=%0d exp all zero",
                     u_if.state, u_if.acq_enable, u_if.fcd_rst, u_if.word_count);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_limit();
        int fcd_cyc;
        logic [7:0] div;
        div = 8'($urandom_range(1, 255));
        do_start(16'hFFFF, 16'h0000, 16'h0000, 32'd4, div);
        fcd_cyc = 0;
        for (int k = 0; k < 10 && u_if.state != 3'd3; k++) begin
            if (u_if.fcd_rst) fcd_cyc++;
            tick();
        end
        n_tests++;
        if (fcd_cyc != 2 || u_if.state !== 3'd3 || u_if.acq_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL limit_rstp got fcd_cyc=%0d state=%0d acq=%b exp 2/3/1",
                     fcd_cyc, u_if.state, u_if.acq_enable);
        end
        n_tests++;
        if (u_if.clock_divisor !== div || u_if.channel_enable !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL limit_capture got div=%0d chan=%h exp %0d/ffff",
                     u_if.clock_divisor, u_if.channel_enable, div);
        end
        u_if.sample_data_avail = 1'b1;
        repeat (4) tick();
        u_if.sample_data_avail = 1'b0;
        n_tests++;
        if (u_if.state !== 3'd4 || u_if.word_count !== 32'd4 || u_if.acq_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL limit_done got state=%0d cnt=%0d acq=%b exp 4/4/0",
                     u_if.state, u_if.word_count, u_if.acq_enable);
        end
    endtask

    task automatic test_trigger();
        bit ok;
        bit held;
        logic [15:0] mask;
        logic [15:0] val;
        for (int pass = 0; pass < 2; pass++) begin
            mask = (pass == 0) ? 16'h0001 : (16'($urandom()) | 16'h0100);
            val  = (pass == 0) ? 16'h0001 : 16'($urandom());
            u_if.probe = val ^ mask;
            do_start(16'h00F0, mask, val, 32'd0, 8'd3);
            wait_state(3'd2, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL trig_armed got state=%0d exp 2", u_if.state);
            end
            held = 1'b1;
            for (int k = 0; k < 10; k++) begin
                u_if.probe = (val ^ mask) ^ (16'($urandom()) & ~mask);
                tick();
                if (u_if.state !== 3'd2 || u_if.acq_enable !== 1'b0) held = 1'b0;
            end
            n_tests++;
            if (!held) begin
                n_fail++;
                $display("FAIL trig_hold got state=%0d acq=%b exp 2/0",
                         u_if.state, u_if.acq_enable);
            end
            u_if.probe = val ^ (16'($urandom()) & ~mask);
            tick();
            n_tests++;
            if (u_if.acq_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL trig_lat1 got acq=%b exp 0", u_if.acq_enable);
            end
            tick();
            n_tests++;
            if (u_if.acq_enable !== 1'b1 || u_if.state !== 3'd3) begin
                n_fail++;
                $display("FAIL trig_lat2 got acq=%b state=%0d exp 1/3",
                         u_if.acq_enable, u_if.state);
            end
            u_if.cmd_abort = 1'b1;
            tick();
            u_if.cmd_abort = 1'b0;
        end
    endtask

    task automatic test_stall_beats_limit();
        bit ok;
        do_start(16'h0003, 16'h0000, 16'h0000, 32'd3, 8'd7);
        wait_state(3'd3, ok);
        u_if.sample_data_avail = 1'b1;
        tick();
        tick();
        u_if.stalled = 1'b1;
        tick();
        u_if.stalled = 1'b0;
        u_if.sample_data_avail = 1'b0;
        n_tests++;
        if (!ok || u_if.state !== 3'd5 || u_if.err_overflow !== 1'b1 ||
            u_if.word_count !== 32'd3 || u_if.acq_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_err got state=%0d ovf=%b cnt=%0d acq=%b exp 5/1/3/0",
                     u_if.state, u_if.err_overflow, u_if.word_count, u_if.acq_enable);
        end
        do_start(16'h0003, 16'h0000, 16'h0000, 32'd3, 8'd7);
        n_tests++;
        if (u_if.err_overflow !== 1'b0 || u_if.word_count !== '0 || u_if.state !== 3'd1) begin
            n_fail++;
            $display("FAIL stall_clear got ovf=%b cnt=%0d state=%0d exp 0/0/1",
                     u_if.err_overflow, u_if.word_count, u_if.state);
        end
        u_if.cmd_abort = 1'b1;
        tick();
        u_if.cmd_abort = 1'b0;
    endtask

    task automatic test_config_error();
        int fcd_seen;
        logic [15:0] chan_before;
        chan_before = exp_chan;
        do_start(16'h0000, 16'h0000, 16'h0000, 32'd5, 8'd99);
        fcd_seen = 0;
        repeat (4) begin
            if (u_if.fcd_rst) fcd_seen++;
            tick();
        end
        n_tests++;
        if (u_if.state !== 3'd5 || u_if.err_config !== 1'b1 || fcd_seen != 0) begin
            n_fail++;
            $display("FAIL cfg_err got state=%0d errcfg=%b fcd=%0d exp 5/1/0",
                     u_if.state, u_if.err_config, fcd_seen);
        end
        n_tests++;
        if (u_if.channel_enable !== chan_before || u_if.clock_divisor !== exp_div) begin
            n_fail++;
            $display("FAIL cfg_hold got chan=%h div=%0d exp %h/%0d",
                     u_if.channel_enable, u_if.clock_divisor, chan_before, exp_div);
        end
    endtask

    task automatic test_abort();
        bit ok;
        do_start(16'h0F00, 16'h0000, 16'h0000, 32'd2, 8'd1);
        wait_state(3'd3, ok);
        u_if.sample_data_avail = 1'b1;
        tick();
        tick();
        u_if.sample_data_avail = 1'b0;
        u_if.cmd_start = 1'b1;
        u_if.cmd_abort = 1'b1;
        tick();
        u_if.cmd_start = 1'b0;
        n_tests++;
        if (!ok || u_if.state !== 3'd0 || u_if.word_count !== 32'd2) begin
            n_fail++;
            $display("FAIL abort_done got state=%0d cnt=%0d exp 0/2",
                     u_if.state, u_if.word_count);
        end
        tick();
        u_if.cmd_abort = 1'b0;
        n_tests++;
        if (u_if.state !== 3'd0 || u_if.word_count !== 32'd2) begin
            n_fail++;
            $display("FAIL abort_idle got state=%0d cnt=%0d exp 0/2",
                     u_if.state, u_if.word_count);
        end
        do_start(16'h0F00, 16'h0000, 16'h0000, 32'd0, 8'd1);
        wait_state(3'd3, ok);
        u_if.sample_data_avail = 1'b1;
        repeat (7) tick();
        u_if.cmd_abort = 1'b1;
        tick();
        u_if.cmd_abort = 1'b0;
        u_if.sample_data_avail = 1'b0;
        n_tests++;
        if (!ok || u_if.state !== 3'd0 || u_if.word_count !== 32'd7 ||
            u_if.acq_enable !== 1'b0 || u_if.fcd_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_run got state=%0d cnt=%0d acq=%b exp 0/7/0",
                     u_if.state, u_if.word_count, u_if.acq_enable);
        end
    endtask

    task automatic test_random_runs();
        bit ok;
        bit s[24];
        int limit;
        int stall_at;
        int cnt;
        int stop;
        logic [2:0] end_state;
        for (int it = 0; it < 20; it++) begin
            limit    = $urandom_range(1, 8);
            stall_at = $urandom_range(0, 35);
            foreach (s[i]) s[i] = ($urandom_range(0, 3) != 0);
            // Outcome of the run: words counted up to the stall or the limit-reaching word.
            cnt = 0;
            stop = -1;
            end_state = 3'd3;
            for (int i = 0; i < 24 && stop < 0; i++) begin
                cnt += int'(s[i]);
                if (i == stall_at) begin
                    end_state = 3'd5;
                    stop = i;
                end else if (s[i] && cnt == limit) begin
                    end_state = 3'd4;
                    stop = i;
                end
            end
            do_start(16'($urandom_range(1, 65535)), 16'h0000, 16'h0000, 32'(limit),
                     8'($urandom()));
            wait_state(3'd3, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL rnd_run_entry it=%0d got state=%0d exp 3", it, u_if.state);
            end
            for (int i = 0; i < 24; i++) begin
                u_if.sample_data_avail = s[i];
                u_if.stalled = (i == stall_at);
                tick();
                n_tests++;
                if (u_if.acq_enable !== (stop < 0 || i < stop)) begin
                    n_fail++;
                    $display("FAIL rnd_acq it=%0d cyc=%0d got %b exp %b", it, i,
                             u_if.acq_enable, (stop < 0 || i < stop));
                end
            end
            u_if.sample_data_avail = 1'b0;
            u_if.stalled = 1'b0;
            n_tests++;
            if (u_if.state !== end_state || u_if.word_count !== 32'(cnt) ||
                u_if.err_overflow !== (end_state == 3'd5)) begin
                n_fail++;
                $display("FAIL rnd_end it=%0d got state=%0d cnt=%0d ovf=%b exp %0d/%0d/%b", it,
                         u_if.state, u_if.word_count, u_if.err_overflow, end_state, cnt,
                         (end_state == 3'd5));
            end
            if (end_state == 3'd3) begin
                u_if.cmd_abort = 1'b1;
                tick();
                u_if.cmd_abort = 1'b0;
            end
        end
    endtask

    task automatic test_unlimited_and_reset();
        bit ok;
        do_start(16'h8001, 16'h0000, 16'h0000, 32'd0, 8'd42);
        wait_state(3'd3, ok);
        u_if.sample_data_avail = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            u_if.cmd_start = (i == 500);
            u_if.cfg_clock_divisor  = 8'd13;
            u_if.cfg_channel_enable = 16'h00FF;
            tick();
        end
        u_if.cmd_start = 1'b0;
        u_if.sample_data_avail = 1'b0;
        n_tests++;
        if (!ok || u_if.state !== 3'd3 || u_if.word_count !== 32'd1000 ||
            u_if.acq_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL unlim_run got state=%0d cnt=%0d acq=%b exp 3/1000/1",
                     u_if.state, u_if.word_count, u_if.acq_enable);
        end
        n_tests++;
        if (u_if.clock_divisor !== 8'd42 || u_if.channel_enable !== 16'h8001) begin
            n_fail++;
            $display("FAIL start_ignored got div=%0d chan=%h exp 42/8001",
                     u_if.clock_divisor, u_if.channel_enable);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (u_if.state !== 3'd0 || u_if.acq_enable !== 1'b0 || u_if.word_count !== '0 ||
            u_if.clock_divisor !== '0 || u_if.channel_enable !== '0 || u_if.fcd_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got state=%0d acq=%b cnt=%0d div=%0d exp all zero",
                     u_if.state, u_if.acq_enable, u_if.word_count, u_if.clock_divisor);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        u_if.cmd_start          = 1'b0;
        u_if.cmd_abort          = 1'b0;
        u_if.cfg_clock_divisor  = '0;
        u_if.cfg_channel_enable = '0;
        u_if.cfg_trig_mask      = '0;
        u_if.cfg_trig_value     = '0;
        u_if.cfg_word_limit     = '0;
        u_if.probe              = '0;
        u_if.sample_data_avail  = 1'b0;
        u_if.stalled            = 1'b0;
        test_reset();
        test_limit();
        test_trigger();
        test_stall_beats_limit();
        test_config_error();
        test_abort();
        test_random_runs();
        test_unlimited_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
